// File: rtl/pe_output_sequencer_pkg.sv
// Shared widths, the latched layer-shape record and the empty-shape test for the
// PE output sequencer.
package pe_output_sequencer_pkg;

  localparam int W_SIZE          = 8;
  localparam int W_CHANNEL       = 6;
  localparam int TOUT            = 4;
  localparam int W_PSUM          = 16;
  localparam int PE_ACCO_FLAT_BW = TOUT * W_PSUM;

  typedef struct packed {
    logic [W_SIZE-1:0]    width;
    logic [W_SIZE-1:0]    height;
    logic [W_CHANNEL-1:0] chn;
    logic [W_CHANNEL-1:0] chn_out;
  } shape_t;

  // A shape with any zero dimension has no beats; the scan ends immediately.
  function automatic logic shape_is_empty(input shape_t s);
    return (s.width == '0) || (s.height == '0) || (s.chn == '0) || (s.chn_out == '0);
  endfunction

endpackage

// File: rtl/pe_output_sequencer_scan_counter4.sv
// Four-level nested wrap counter: col innermost, then row, chn, chn_out.
// Every advance moves col; each wrap carries one level outward.
module pe_output_sequencer_scan_counter4
  import pe_output_sequencer_pkg::*;
(
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 clear_i,
  input  logic                 adv_i,
  input  logic [W_SIZE-1:0]    lim_width_i,
  input  logic [W_SIZE-1:0]    lim_height_i,
  input  logic [W_CHANNEL-1:0] lim_chn_i,
  input  logic [W_CHANNEL-1:0] lim_chn_out_i,
  output logic [W_SIZE-1:0]    col_o,
  output logic [W_SIZE-1:0]    row_o,
  output logic [W_CHANNEL-1:0] chn_o,
  output logic [W_CHANNEL-1:0] chn_out_o,
  output logic                 is_last_chn_o,
  output logic                 is_final_o
);

  logic [W_SIZE-1:0]    col_q, col_d, row_q, row_d;
  logic [W_CHANNEL-1:0] chn_q, chn_d, cout_q, cout_d;
  logic                 col_max, row_max, chn_max, cout_max;

  assign col_max  = (col_q  == lim_width_i   - W_SIZE'(1));
  assign row_max  = (row_q  == lim_height_i  - W_SIZE'(1));
  assign chn_max  = (chn_q  == lim_chn_i     - W_CHANNEL'(1));
  assign cout_max = (cout_q == lim_chn_out_i - W_CHANNEL'(1));

  always_comb begin
    col_d  = col_q;
    row_d  = row_q;
    chn_d  = chn_q;
    cout_d = cout_q;
    if (clear_i) begin
      col_d  = '0;
      row_d  = '0;
      chn_d  = '0;
      cout_d = '0;
    end else if (adv_i) begin
      if (!col_max) begin
        col_d = col_q + W_SIZE'(1);
      end else begin
        col_d = '0;
        if (!row_max) begin
          row_d = row_q + W_SIZE'(1);
        end else begin
          row_d = '0;
          if (!chn_max) begin
            chn_d = chn_q + W_CHANNEL'(1);
          end else begin
            chn_d  = '0;
            cout_d = cout_max ? '0 : cout_q + W_CHANNEL'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      col_q  <= '0;
      row_q  <= '0;
      chn_q  <= '0;
      cout_q <= '0;
    end else begin
      col_q  <= col_d;
      row_q  <= row_d;
      chn_q  <= chn_d;
      cout_q <= cout_d;
    end
  end

  assign col_o         = col_q;
  assign row_o         = row_q;
  assign chn_o         = chn_q;
  assign chn_out_o     = cout_q;
  assign is_last_chn_o = chn_max;
  assign is_final_o    = col_max && row_max && chn_max && cout_max;

endmodule

// File: rtl/pe_output_sequencer.sv
// Tags each PE accumulator beat with its (chn_out, chn, row, col) coordinates and
// forwards it one cycle later; owns the layer-scan FSM and counters.
module pe_output_sequencer
  import pe_output_sequencer_pkg::*;
(
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       start_i,
  input  logic [W_SIZE-1:0]          q_width,
  input  logic [W_SIZE-1:0]          q_height,
  input  logic [W_CHANNEL-1:0]       q_channel,
  input  logic [W_CHANNEL-1:0]       q_channel_out,
  input  logic                       acc_vld_i,
  input  logic [PE_ACCO_FLAT_BW-1:0] acc_data_i,
  output logic [PE_ACCO_FLAT_BW-1:0] pe_data_o,
  output logic                       pe_vld_o,
  output logic [W_SIZE-1:0]          pe_row_o,
  output logic [W_SIZE-1:0]          pe_col_o,
  output logic [W_CHANNEL-1:0]       pe_chn_o,
  output logic [W_CHANNEL-1:0]       pe_chn_out_o,
  output logic                       pe_is_last_chn_o,
  output logic                       busy_o,
  output logic                       done_o,
  output logic                       err_o,
  output logic [1:0]                 dbg_state_o
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Handshake: acc_vld_i has no ready. Every beat presented in RUN is accepted
  // that cycle; beats in any other state are dropped and flag err_o.
  logic [1:0]           state_q, state_d;
  shape_t               shape_q, shape_in;
  logic                 start_ok, accept, err_d;
  logic [W_SIZE-1:0]    cnt_col, cnt_row;
  logic [W_CHANNEL-1:0] cnt_chn, cnt_cout;
  logic                 cnt_last_chn, cnt_final;

  assign shape_in = '{width: q_width, height: q_height, chn: q_channel, chn_out: q_channel_out};
  assign start_ok = start_i && (state_q == ST_IDLE);
  assign accept   = acc_vld_i && (state_q == ST_RUN);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start_ok) state_d = shape_is_empty(shape_in) ? ST_DONE : ST_RUN;
      ST_RUN:  if (accept && cnt_final) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // A start clears the sticky error, but a beat dropped in the same cycle re-raises it.
  always_comb begin
    err_d = err_o;
    if (start_ok) err_d = 1'b0;
    if (acc_vld_i && (state_q != ST_RUN)) err_d = 1'b1;
  end

  pe_output_sequencer_scan_counter4 u_scan (
    .clk           (clk),
    .rstn          (rstn),
    .clear_i       (start_ok),
    .adv_i         (accept),
    .lim_width_i   (shape_q.width),
    .lim_height_i  (shape_q.height),
    .lim_chn_i     (shape_q.chn),
    .lim_chn_out_i (shape_q.chn_out),
    .col_o         (cnt_col),
    .row_o         (cnt_row),
    .chn_o         (cnt_chn),
    .chn_out_o     (cnt_cout),
    .is_last_chn_o (cnt_last_chn),
    .is_final_o    (cnt_final)
  );

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q          <= ST_IDLE;
      shape_q          <= '0;
      pe_data_o        <= '0;
      pe_vld_o         <= 1'b0;
      pe_row_o         <= '0;
      pe_col_o         <= '0;
      pe_chn_o         <= '0;
      pe_chn_out_o     <= '0;
      pe_is_last_chn_o <= 1'b0;
      busy_o           <= 1'b0;
      done_o           <= 1'b0;
      err_o            <= 1'b0;
    end else begin
      state_q  <= state_d;
      err_o    <= err_d;
      busy_o   <= (state_d == ST_RUN);
      done_o   <= (state_d == ST_DONE);
      pe_vld_o <= accept;
      if (start_ok) shape_q <= shape_in;
      if (accept) begin
        pe_data_o        <= acc_data_i;
        pe_row_o         <= cnt_row;
        pe_col_o         <= cnt_col;
        pe_chn_o         <= cnt_chn;
        pe_chn_out_o     <= cnt_cout;
        pe_is_last_chn_o <= cnt_last_chn;
      end
    end
  end

  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_pe_output_sequencer.sv
// Self-checking bench for pe_output_sequencer: directed scenarios plus random
// shapes and gaps, checked against an index-arithmetic reference model.
module tb_pe_output_sequencer;
  import pe_output_sequencer_pkg::*;

  localparam int DW = PE_ACCO_FLAT_BW;

  logic                 clk = 1'b0;
  logic                 rstn;
  logic                 start_i;
  logic [W_SIZE-1:0]    q_width, q_height;
  logic [W_CHANNEL-1:0] q_channel, q_channel_out;
  logic                 acc_vld_i;
  logic [DW-1:0]        acc_data_i;
  logic [DW-1:0]        pe_data_o;
  logic                 pe_vld_o;
  logic [W_SIZE-1:0]    pe_row_o, pe_col_o;
  logic [W_CHANNEL-1:0] pe_chn_o, pe_chn_out_o;
  logic                 pe_is_last_chn_o, busy_o, done_o, err_o;
  logic [1:0]           dbg_state_o;

  pe_output_sequencer dut (
    .clk              (clk),
    .rstn             (rstn),
    .start_i          (start_i),
    .q_width          (q_width),
    .q_height         (q_height),
    .q_channel        (q_channel),
    .q_channel_out    (q_channel_out),
    .acc_vld_i        (acc_vld_i),
    .acc_data_i       (acc_data_i),
    .pe_data_o        (pe_data_o),
    .pe_vld_o         (pe_vld_o),
    .pe_row_o         (pe_row_o),
    .pe_col_o         (pe_col_o),
    .pe_chn_o         (pe_chn_o),
    .pe_chn_out_o     (pe_chn_out_o),
    .pe_is_last_chn_o (pe_is_last_chn_o),
    .busy_o           (busy_o),
    .done_o           (done_o),
    .err_o            (err_o),
    .dbg_state_o      (dbg_state_o)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int unsigned   n_cmp = 0;
  int unsigned   n_err = 0;
  logic [DW-1:0] exp_q[$];
  bit            m_scan, m_post, m_err;
  int            m_idx, m_total, m_w, m_h, m_c, m_co;
  int            e_row, e_col, e_chn, e_co;
  bit            e_last;
  logic [DW-1:0] e_data;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_scan = 0; m_post = 0; m_err = 0;
    m_idx = 0; m_total = 0; m_w = 0; m_h = 0; m_c = 0; m_co = 0;
    e_row = 0; e_col = 0; e_chn = 0; e_co = 0; e_last = 0; e_data = '0;
    exp_q.delete();
  endtask

  task automatic set_shape(input int w, input int h, input int c, input int co);
    q_width = W_SIZE'(w); q_height = W_SIZE'(h);
    q_channel = W_CHANNEL'(c); q_channel_out = W_CHANNEL'(co);
  endtask

  task automatic check_all(input bit e_vld, input bit e_done);
    check("vld",  64'(pe_vld_o), 64'(e_vld));
    check("done", 64'(done_o),   64'(e_done));
    check("busy", 64'(busy_o),   64'(m_scan));
    check("err",  64'(err_o),    64'(m_err));
    check("row",  64'(pe_row_o), 64'(e_row));
    check("col",  64'(pe_col_o), 64'(e_col));
    check("chn",  64'(pe_chn_o), 64'(e_chn));
    check("chn_out", 64'(pe_chn_out_o), 64'(e_co));
    check("last", 64'(pe_is_last_chn_o), 64'(e_last));
    check("data", 64'(pe_data_o), 64'(e_data));
  endtask

  // ---------------- driver ----------------
  task automatic step(input bit st, input bit v, input logic [DW-1:0] d);
    bit was_scan, can_start, e_vld, e_done;
    @(negedge clk);
    start_i = st; acc_vld_i = v; acc_data_i = d;
    was_scan  = m_scan;
    can_start = !m_scan && !m_post;
    e_vld = 0; e_done = 0;
    if (v && was_scan) begin
      e_vld  = 1;
      e_col  = m_idx % m_w;
      e_row  = (m_idx / m_w) % m_h;
      e_chn  = (m_idx / (m_w * m_h)) % m_c;
      e_co   = m_idx / (m_w * m_h * m_c);
      e_last = (e_chn == m_c - 1);
      exp_q.push_back(d);
      m_idx++;
      if (m_idx == m_total) begin m_scan = 0; e_done = 1; end
    end
    if (st && can_start) begin
      m_err = 0;
      m_w = int'(q_width); m_h = int'(q_height);
      m_c = int'(q_channel); m_co = int'(q_channel_out);
      m_total = m_w * m_h * m_c * m_co;
      m_idx = 0;
      if (m_total == 0) e_done = 1; else m_scan = 1;
    end
    if (v && !was_scan) m_err = 1;
    m_post = e_done;
    @(posedge clk); #1;
    if (e_vld && exp_q.size() > 0) e_data = exp_q.pop_front();
    check_all(e_vld, e_done);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 0; start_i = 0; acc_vld_i = 0; acc_data_i = '0;
    @(posedge clk); #1;
    model_clear();
    check_all(0, 0);
    @(negedge clk);
    rstn = 1;
  endtask

  function automatic logic [DW-1:0] rand_data();
    return {$urandom, $urandom};
  endfunction

  // ---------------- scenarios ----------------
  int gaps[3] = '{0, 2, 5};
  int budget;

  initial begin
    rstn = 1; start_i = 0; acc_vld_i = 0; acc_data_i = '0;
    set_shape(0, 0, 0, 0);
    model_clear();
    do_reset();

    // stray beat in IDLE
    step(0, 1, rand_data());
    step(0, 0, '0);

    // basic scan 2x2x1x1, lane values = beat number
    set_shape(2, 2, 1, 1);
    step(1, 0, '0);
    for (int b = 1; b <= 4; b++) step(0, 1, {TOUT{W_PSUM'(b)}});
    step(0, 0, '0);

    // channel wrap 1x1x3x2
    set_shape(1, 1, 3, 2);
    step(1, 0, '0);
    for (int b = 0; b < 6; b++) step(0, 1, rand_data());
    step(0, 0, '0);

    // gapped input 3x1x1x1
    set_shape(3, 1, 1, 1);
    step(1, 0, '0);
    for (int b = 0; b < 3; b++) begin
      for (int g = 0; g < gaps[b]; g++) step(0, 0, '0);
      step(0, 1, rand_data());
    end
    step(0, 0, '0);

    // start mid-scan ignored; shape inputs change but are not sampled
    set_shape(2, 1, 1, 1);
    step(1, 0, '0);
    step(0, 1, rand_data());
    set_shape(3, 3, 3, 3);
    step(1, 1, rand_data());
    step(1, 0, '0);
    step(0, 0, '0);

    // reset after beat 5 of 2x2x2x1, then a full fresh scan
    set_shape(2, 2, 2, 1);
    step(1, 0, '0);
    for (int b = 0; b < 5; b++) step(0, 1, rand_data());
    do_reset();
    step(1, 0, '0);
    for (int b = 0; b < 8; b++) step(0, 1, rand_data());
    step(0, 0, '0);

    // empty shape
    set_shape(2, 0, 1, 1);
    step(1, 0, '0);
    step(0, 0, '0);

    // start together with a stray beat in IDLE
    set_shape(1, 2, 1, 1);
    step(1, 1, rand_data());
    step(0, 1, rand_data());
    step(0, 1, rand_data());
    step(0, 0, '0);

    // random shapes, gaps and stray starts/beats
    for (int s = 0; s < 25; s++) begin
      set_shape($urandom_range(0, 3), $urandom_range(0, 3),
                $urandom_range(0, 3), $urandom_range(0, 3));
      step(1, ($urandom_range(0, 7) == 0), rand_data());
      budget = 0;
      while ((m_scan || m_post) && budget < 400) begin
        step(($urandom_range(0, 9) == 0), ($urandom_range(0, 3) != 0), rand_data());
        budget++;
      end
      check("scan_budget", 64'(m_scan), 64'(0));
      for (int g = 0; g < $urandom_range(0, 2); g++) step(0, 0, '0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pe_output_sequencer.md
# pe_output_sequencer

Transmit side of the PE-to-postprocessor interface. Takes the stream of raw Tout-lane accumulator vectors from the PE array and tags each beat with the row, column, input-channel tile and output-channel tile it belongs to, plus a last-input-channel flag. It sits between the PE array and `postprocessor`, which accumulates partial sums using these coordinates. It holds all layer-scan counters, so the PE array stays coordinate-free.

## Interface
Parameters:
- `W_SIZE`, `W_SIZE` macro: width of row/col/size fields.
- `W_CHANNEL`, `W_CHANNEL` macro: width of tiled channel fields.
- `Tout`, `Tout` macro (4): output lanes per beat.
- `PSUM_DW`, `W_PSUM` macro: bits per lane.
- `PE_ACCO_FLAT_BW`, `PE_ACCO_FLAT_BW` macro (= Tout*PSUM_DW): flat beat width.

Ports:
- `clk` in 1: single clock; all logic on rising edge.
- `rstn` in 1: reset, synchronous, active-low.
- `start_i` in 1: one-cycle pulse; latches the layer shape and begins a scan.
- `q_width`, `q_height` in W_SIZE: layer width and height in pixels.
- `q_channel`, `q_channel_out` in W_CHANNEL: input and output channel tile counts.
- `acc_vld_i` in 1: PE array presents one accumulator beat.
- `acc_data_i` in PE_ACCO_FLAT_BW: the beat; lane g is at `[(g+1)*PSUM_DW-1 -: PSUM_DW]`.
- `pe_data_o` out PE_ACCO_FLAT_BW: registered copy of the beat.
- `pe_vld_o` out 1: beat valid.
- `pe_row_o`, `pe_col_o` out W_SIZE: pixel coordinates of the beat.
- `pe_chn_o`, `pe_chn_out_o` out W_CHANNEL: input and output tile indices.
- `pe_is_last_chn_o` out 1: high when `pe_chn_o == q_channel-1`.
- `busy_o` out 1: scan in progress.
- `done_o` out 1: one-cycle pulse when the scan completes.
- `err_o` out 1: sticky protocol error; cleared only by reset or `start_i`.

## Operation
- FSM has three states: IDLE, RUN, DONE.
  - IDLE → RUN on `start_i`. Shape is latched and counters are zeroed.
  - RUN → DONE on acceptance of the final beat.
  - DONE → IDLE unconditionally after one cycle.
- If any latched dimension is 0, `start_i` goes IDLE → DONE directly and no beats are emitted.
- Scan order, outermost to innermost: `chn_out` (0..q_channel_out-1), `chn` (0..q_channel-1), `row` (0..q_height-1), `col` (0..q_width-1).
- Every `acc_vld_i` in RUN consumes exactly one coordinate tuple, then advances `col`.
  - Wrap at `q_width-1` carries into `row`, then `chn`, then `chn_out`.
  - The final beat is the one where all four counters are at their maxima.
- Total beats per scan = W·H·C·Cout.
- There is no backpressure: the postprocessor accepts every beat, and the PE array may assert `acc_vld_i` on consecutive cycles.
- Data passes through bit-exact; no arithmetic on lanes.
- `acc_vld_i` outside RUN:
  - The beat is dropped and `err_o` is set.
  - Counters do not move.
  - `pe_vld_o` stays 0 for that beat.
- `start_i` while RUN or DONE is ignored and does not set `err_o`. Shape inputs are sampled only at an accepted `start_i`.
- `start_i` together with `acc_vld_i` in IDLE: start is taken and the beat is dropped with `err_o` set (the scan begins the following cycle).

## Timing
- Latency is 1 cycle: beat on `acc_vld_i` at cycle N → `pe_vld_o`, data and coordinates at N+1. All outputs are registered.
- `pe_vld_o` is high only in cycles following an accepted beat. The coordinate outputs hold their last value otherwise.
- `busy_o` is 1 from the cycle after accepted `start_i` through the cycle the final beat is accepted.
- `done_o` is high exactly in the cycle the final beat appears on `pe_vld_o`. For an empty shape, it is the cycle after `start_i`.
- A new `start_i` is accepted in the cycle after `done_o`.
- Reset (`rstn`=0 at a clock edge), including mid-scan, clears on the next edge:
  - State returns to IDLE and counters are cleared.
  - All outputs go to 0: `pe_data_o`, `pe_vld_o`, coordinates, `pe_is_last_chn_o`, `busy_o`, `done_o`, `err_o`.

## Structure
- Shared widths come from `controller_params.vh`: W_SIZE, W_CHANNEL, Tout, W_PSUM, PE_ACCO_FLAT_BW.
- FSM state encodings are local to this block.
- Natural sub-module: `scan_counter4`, a four-level nested wrap counter. It has inputs for the four limits and an advance strobe, and outputs for the four indices, `is_last_chn`, and `is_final`.
- Output register stage lives in the top module.

## Test plan
- **Basic scan.** Shape W=2, H=2, C=1, Cout=1; four back-to-back beats with lane values 1..4.
  - Outputs (row,col) are (0,0),(0,1),(1,0),(1,1), all `pe_is_last_chn_o`=1.
  - Data is identical and delayed 1 cycle; `done_o` coincides with the 4th `pe_vld_o`.
- **Channel wrap.** Shape W=1, H=1, C=3, Cout=2; six beats.
  - `(chn_out,chn)` sequence is (0,0),(0,1),(0,2),(1,0),(1,1),(1,2).
  - `pe_is_last_chn_o` is high on beats 3 and 6 only.
- **Gapped input.** W=3, H=1, C=1, Cout=1 with `acc_vld_i` idle gaps of 0, 2 and 5 cycles.
  - Coordinates still advance only per beat.
  - `busy_o` stays high until the 3rd beat.
- **Error and ignore cases.**
  - `acc_vld_i` in IDLE → `err_o`=1 and `pe_vld_o`=0.
  - `start_i` mid-scan → ignored; scan completes with the original shape.
- **Reset mid-scan.** `rstn`=0 after beat 5 of a 2×2×2×1 scan → all outputs 0 next cycle.
  - A fresh `start_i` then produces a full 8-beat scan starting at (0,0,0,0).
- **Empty shape.** `start_i` with q_height=0 → `done_o` pulse one cycle later, no `pe_vld_o`, `err_o`=0.
